// File: rtl/prog_seq_pkg.sv
// rtl/prog_seq_pkg.sv - shared state encoding and default parameters for prog_sequencer
package prog_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int DEF_D          = 12;
    localparam int DEF_LUT_AW     = 4;
    localparam int DEF_START_ADDR = 0;
    localparam int DEF_END_ADDR   = 50;
    localparam int DEF_CW         = 16;

endpackage

// File: rtl/prog_sequencer_branch_lut.sv
// rtl/prog_sequencer_branch_lut.sv - branch-target LUT, one sync write port, one comb read port
module branch_lut #(
    parameter int AW = 4,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int ENTRIES = 1 << AW;

    logic [DW-1:0] mem [ENTRIES];

    // Read is combinational from the array, so a same-cycle write is seen only after the edge.
    assign rdata = mem[raddr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - run-control FSM, program counter and run-cycle counter
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int D          = DEF_D,
    parameter int LUT_AW     = DEF_LUT_AW,
    parameter int START_ADDR = DEF_START_ADDR,
    parameter int END_ADDR   = DEF_END_ADDR,
    parameter int CW         = DEF_CW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              halt,
    input  logic              relj,
    input  logic              absj,
    input  logic [D-1:0]      rel_off,
    input  logic [LUT_AW-1:0] lut_idx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [D-1:0]      lut_wdata,
    output logic [D-1:0]      prog_ctr,
    output logic              run,
    output logic              done,
    output logic [CW-1:0]     cycles
);

    localparam logic [D-1:0] START_PC = D'(START_ADDR);
    localparam logic [D-1:0] END_PC   = D'(END_ADDR);

    seq_state_t    state_q;
    seq_state_t    state_d;
    logic [D-1:0]  lut_rdata;
    logic          finish;

    branch_lut #(
        .AW (LUT_AW),
        .DW (D)
    ) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (lut_idx),
        .rdata (lut_rdata)
    );

    assign finish = halt || (prog_ctr == END_PC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req)     state_d = RUN;
            RUN:     if (finish)  state_d = DONE;
            DONE:    if (!req)    state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        run  = (state_q == RUN);
        done = (state_q == DONE);
    end

    // The terminating cycle still counts as a RUN cycle but leaves the PC where it stopped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prog_ctr <= START_PC;
            cycles   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        prog_ctr <= START_PC;
                        cycles   <= '0;
                    end
                end
                RUN: begin
                    if (cycles != '1) begin
                        cycles <= cycles + CW'(1);
                    end
                    if (!finish) begin
                        if (absj) begin
                            prog_ctr <= lut_rdata;
                        end else if (relj) begin
                            prog_ctr <= prog_ctr + rel_off;
                        end else begin
                            prog_ctr <= prog_ctr + D'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Parametrised run-control and program-counter block for the next-generation core.
- Replaces the fixed PC + branch LUT + hard-wired "done at PC==50" arrangement.
- Adds a four-phase req/done handshake, a runtime-writable branch-target LUT, a halt input, signed relative jumps and a run-cycle counter.
- Sits between the testbench/host and the instruction ROM; its prog_ctr drives instruction fetch, and its run output gates register/memory write enables in the datapath.

Parameters:
D, 12, program counter width
LUT_AW, 4, branch-target LUT index width (2**LUT_AW entries)
START_ADDR, 0, PC value loaded on each start
END_ADDR, 50, PC value that terminates a run
CW, 16, cycle counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  start request, level, four-phase handshake
halt  input  1  current instruction is a halt (from control decode)
relj  input  1  relative jump taken this cycle
absj  input  1  absolute (LUT) jump taken this cycle
rel_off  input  D  signed relative offset, two's complement
lut_idx  input  LUT_AW  LUT read index for absj
lut_we  input  1  LUT write enable
lut_waddr  input  LUT_AW  LUT write index
lut_wdata  input  D  LUT write data
prog_ctr  output  D  current program counter
run  output  1  high while in RUN (datapath writes permitted)
done  output  1  run complete, four-phase acknowledge
cycles  output  CW  RUN cycles in last/current run

Behaviour:
- One clock domain (clk). Asynchronous active-high reset.
- Reset values:
  - state=IDLE, prog_ctr=START_ADDR, run=0, done=0, cycles=0.
  - All LUT entries=0.
- All outputs are registered or decoded from state only; no combinational input-to-output path.
- States:
  - IDLE: run=0, done=0, prog_ctr holds. req=1 -> RUN; prog_ctr<=START_ADDR, cycles<=0.
  - RUN: run=1.
    - If halt=1 or prog_ctr==END_ADDR -> DONE; prog_ctr holds; relj/absj ignored; cycles increments for this final cycle.
    - Otherwise the PC updates, first match wins:
      - absj -> prog_ctr<=lut[lut_idx]
      - relj -> prog_ctr<=prog_ctr+rel_off, modulo 2**D (wraps in both directions)
      - otherwise prog_ctr<=prog_ctr+1, modulo 2**D
    - cycles increments each RUN cycle and saturates at all-ones.
    - req is ignored in RUN: dropping req does not abort the run.
  - DONE: done=1, run=0, prog_ctr and cycles hold. req=0 -> IDLE (done falls the following cycle).
- Latency:
  - req high in IDLE at edge N -> run=1 and prog_ctr=START_ADDR after edge N.
  - Termination condition seen at edge M -> done=1 after edge M.
- absj and relj both high: absj wins.
- If START_ADDR==END_ADDR, a run lasts exactly one RUN cycle (cycles=1).
- LUT write/read:
  - Writes are accepted in any state and take effect at the clock edge.
  - A same-cycle write and absj read of the same index returns the OLD value.
- Reset mid-run: immediate return to IDLE with the reset values above. LUT contents are cleared.

Decomposition:
- Package prog_seq_pkg holds:
  - state enum seq_state_t {IDLE, RUN, DONE}, 2-bit encoding
  - default parameter constants
- Sub-module branch_lut:
  - 2**LUT_AW x D register array
  - one synchronous write port, one combinational read port
  - async reset clears all entries
- FSM, PC update and cycle counter stay in prog_sequencer.

Test Plan:
1. Start and terminate at END_ADDR.
   - Stimulus: reset, then req=1 held; no jumps; END_ADDR=50.
   - Required: prog_ctr steps 0..50; done=1 one cycle after PC==50; cycles=51; run falls with done.
   - Then req=0 -> done=0 next cycle; state returns to IDLE.
2. LUT jump and simultaneous jump.
   - Stimulus: write lut[3]=12'd40; in RUN at PC=5 assert absj, lut_idx=3.
   - Required: PC=40 next cycle.
   - Stimulus: repeat with relj=1, rel_off=2 in the same cycle.
   - Required: PC=40 (absj wins).
3. Relative jump with wrap.
   - Stimulus: at PC=10, relj with rel_off=-3 (12'hFFD).
   - Required: PC=7.
   - Stimulus: at PC=12'hFFF with no jump.
   - Required: PC=0. (Run with END_ADDR above reached values.)
4. Halt.
   - Stimulus: halt=1 at PC=7 with relj=1 in the same cycle.
   - Required: PC stays 7, done=1 next cycle, cycles=8.
5. LUT write/read collision.
   - Stimulus: lut[2]=20, then in the same cycle lut_we=1 writing lut[2]=30 with absj, lut_idx=2.
   - Required: PC=20.
   - Stimulus: a later absj to index 2.
   - Required: PC=30.
6. Reset mid-run.
   - Stimulus: assert reset asynchronously at PC=17 between edges.
   - Required: prog_ctr=0, run=0, done=0, cycles=0 immediately, and LUT reads return 0.
   - Stimulus: req still high after reset release.
   - Required: new run starts at START_ADDR.
